sub_magnitude_seq: RTL and testbench
====================================

# sub_magnitude_seq

Multi-cycle, parametrised add/subtract unit that computes a `WIDTH`-bit result one `CHUNK`-bit slice per cycle, LSB first. It offers four modes, including sign-magnitude absolute difference with a negative flag and saturating subtract. Operands enter and results leave through valid/ready handshakes. It sits in the arithmetic datapath wherever a narrow, area-cheap carry chain is preferred over a single-cycle `WIDTH`-bit adder.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width; must be a multiple of `CHUNK`
- `CHUNK`, 4, slice width processed per cycle; `N = WIDTH/CHUNK` slices

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operands and mode present
- `in_ready`  out  1  unit can accept; high only in IDLE
- `a`, `b`  in  `WIDTH` each  unsigned operands
- `mode`  in  2  00 ADD, 01 SUB (wrap), 10 ABSDIFF, 11 SATSUB
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer takes result
- `result`  out  `WIDTH`  result
- `neg`  out  1  1 in SUB/ABSDIFF/SATSUB when a < b; 0 in ADD
- `carry`  out  1  carry-out of raw operation; for subtract modes 1 means a ≥ b (no borrow)

## Operation
- Accept: when `in_valid && in_ready`, `a`, `b` and `mode` are registered. The inputs may then change freely.
- Raw operation: ADD computes a + b. All other modes compute a + ~b + 1, with the initial carry-in of 1.
- States:
  - IDLE → CALC on accept; slice index and carry are initialised.
  - CALC processes slice `idx` each cycle and stores the partial sum and carry-out. After slice N-1:
    - go to NEG if mode = ABSDIFF and the final carry = 0;
    - otherwise go to DONE.
  - NEG forms the two's complement of the raw result, one slice per cycle: slices are inverted and propagated with carry-in 1. It goes to DONE after slice N-1.
  - DONE holds `out_valid = 1` and all outputs stable until `out_ready`, then returns to IDLE.
- Result per mode:
  - ADD: low `WIDTH` bits of the sum; `neg` = 0.
  - SUB: wrap-around difference.
  - ABSDIFF: |a − b|.
  - SATSUB: 0 if a < b, else a − b. The substitution is applied when entering DONE, with no NEG phase.
- a == b: result 0, `neg` = 0, `carry` = 1 in all subtract modes.
- The unit holds one transaction at a time and has no overlap.

## Timing
- Reset (async assert, sync release) values:
  - state IDLE, `in_ready` = 1, `out_valid` = 0, `result` = 0, `neg` = 0, `carry` = 0
  - internal slice registers and index = 0
- Latency, counted from the accepting edge to the first cycle with `out_valid` high:
  - N cycles for ADD, SUB, SATSUB, and ABSDIFF with a ≥ b
  - 2N cycles for ABSDIFF with a < b
- `in_ready` is low from the accepting edge until the cycle after `out_valid && out_ready`. Minimum issue interval is latency + 1 cycles.
- `result`, `neg` and `carry` change only on entry to DONE. They are don't-care-free: they keep their last values outside DONE.
- `out_ready` asserted before DONE has no effect.
- A reset asserted mid-CALC or mid-NEG aborts the transaction immediately. Outputs return to their reset values and no stale `out_valid` appears after release.
- `mode` 11 is a legal mode, not reserved. There are no illegal encodings.

## Structure
- Shared package `arith_pkg` contains:
  - `mode_t` enum (ADD, SUB, ABSDIFF, SATSUB)
  - `state_t` enum (IDLE, CALC, NEG, DONE)
  - a helper function for the slice count
- Sub-module `chunk_adder`: combinational `CHUNK`-bit adder with carry-in/carry-out. It is instantiated once and shared between the CALC and NEG phases. In NEG, its operands are the inverted raw slice and zero.
- Top level holds the FSM, slice index counter, operand/result shift registers, and output registers.
- An elaboration-time check rejects configurations where `WIDTH % CHUNK != 0`.

## Test plan
- WIDTH=8, CHUNK=4, ABSDIFF, a=3, b=10 → `result` = 7, `neg` = 1, `carry` = 0, `out_valid` 4 cycles after accept.
- SUB, a=3, b=10 → `result` = 0xF9, `neg` = 1, `carry` = 0, latency 2. Same case with SATSUB → `result` = 0, `neg` = 1, latency 2.
- ADD, a=200, b=100 → `result` = 44, `carry` = 1, `neg` = 0. Also ABSDIFF a = b = 0x5A → `result` = 0, `neg` = 0, `carry` = 1.
- Backpressure: hold `out_ready` = 0 for 5 cycles in DONE → outputs stable, `in_ready` = 0. Then `in_valid` with new operands is accepted only the cycle after the handshake. Change `a`/`b` during CALC → result is unaffected.
- Reset mid-transaction: assert `rst_n` = 0 during NEG → `out_valid` = 0, `result` = 0, `in_ready` = 1 after release. The next transaction completes correctly.
- Parameter sweep: WIDTH=16 with CHUNK ∈ {1, 4, 16}, random operands and modes vs. a reference model. Latency is N or 2N exactly; CHUNK=16 gives 1 or 2 cycles.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared types and helpers for the sliced add/subtract datapath.
package arith_pkg;

  typedef enum logic [1:0] {
    MODE_ADD     = 2'b00,
    MODE_SUB     = 2'b01,
    MODE_ABSDIFF = 2'b10,
    MODE_SATSUB  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    NEG,
    DONE
  } state_t;

  function automatic int unsigned slice_count(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder with carry-in/carry-out, shared by CALC and NEG.
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  always_comb begin
    {cout, sum} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
  end

endmodule

// File: rtl/sub_magnitude_seq.sv
// Multi-cycle add/sub/absdiff/satsub unit, one CHUNK-bit slice per cycle, LSB first.
module sub_magnitude_seq
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             neg,
  output logic             carry
);

  localparam int unsigned N  = slice_count(WIDTH, CHUNK);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("sub_magnitude_seq: WIDTH must be a multiple of CHUNK");
  end

  state_t           state;
  mode_t            mode_r;
  logic [WIDTH-1:0] a_sh, b_sh, raw, raw_next;
  logic [IW-1:0]    idx;
  logic             cy, raw_carry;
  logic [CHUNK-1:0] x, y, sum;
  logic             cout;

  chunk_adder #(.CHUNK(CHUNK)) u_adder (
    .x    (x),
    .y    (y),
    .cin  (cy),
    .sum  (sum),
    .cout (cout)
  );

  // NEG reuses the adder as ~slice + 0 + carry, rippling the +1 of the two's complement
  always_comb begin
    x = '0;
    y = '0;
    if (state == NEG) begin
      x = ~raw[CHUNK-1:0];
    end else begin
      x = a_sh[CHUNK-1:0];
      y = (mode_r == MODE_ADD) ? b_sh[CHUNK-1:0] : ~b_sh[CHUNK-1:0];
    end
    raw_next = (raw >> CHUNK) | (WIDTH'(sum) << (WIDTH - CHUNK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_r    <= MODE_ADD;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      neg       <= 1'b0;
      carry     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      raw       <= '0;
      idx       <= '0;
      cy        <= 1'b0;
      raw_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            mode_r   <= mode_t'(mode);
            cy       <= (mode != 2'b00);
            raw      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          a_sh <= a_sh >> CHUNK;
          b_sh <= b_sh >> CHUNK;
          raw  <= raw_next;
          cy   <= cout;
          idx  <= idx + IW'(1);
          if (idx == LAST) begin
            idx       <= '0;
            raw_carry <= cout;
            if (mode_r == MODE_ABSDIFF && !cout) begin
              cy    <= 1'b1;
              state <= NEG;
            end else begin
              out_valid <= 1'b1;
              carry     <= cout;
              neg       <= (mode_r != MODE_ADD) && !cout;
              result    <= (mode_r == MODE_SATSUB && !cout) ? '0 : raw_next;
              state     <= DONE;
            end
          end
        end
        NEG: begin
          raw <= raw_next;
          cy  <= cout;
          idx <= idx + IW'(1);
          if (idx == LAST) begin
            idx       <= '0;
            out_valid <= 1'b1;
            carry     <= raw_carry;
            neg       <= 1'b1;
            result    <= raw_next;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_magnitude_seq.sv
// Scoreboard bench for sub_magnitude_seq: 8/4 directed cases plus a 16-bit CHUNK sweep.
module tb_sub_magnitude_seq;

  typedef struct {
    logic [15:0] res;
    logic        neg;
    logic        carry;
    int          lat;
  } exp_t;

  int checks = 0;
  int failures = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0, b = '0;
  logic [1:0] mode = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic       neg, carry;

  logic        iv16 = 1'b0;
  logic        or16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0;
  logic [1:0]  m16 = '0;
  logic        ir16[3];
  logic        ov16[3];
  logic [15:0] r16[3];
  logic        ng16[3];
  logic        cy16[3];

  exp_t q8[$];
  exp_t qs[3][$];

  always #5 clk = ~clk;

  sub_magnitude_seq #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .neg(neg), .carry(carry)
  );

  sub_magnitude_seq #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16[0]),
    .a(a16), .b(b16), .mode(m16), .out_valid(ov16[0]), .out_ready(or16),
    .result(r16[0]), .neg(ng16[0]), .carry(cy16[0])
  );

  sub_magnitude_seq #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16[1]),
    .a(a16), .b(b16), .mode(m16), .out_valid(ov16[1]), .out_ready(or16),
    .result(r16[1]), .neg(ng16[1]), .carry(cy16[1])
  );

  sub_magnitude_seq #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16[2]),
    .a(a16), .b(b16), .mode(m16), .out_valid(ov16[2]), .out_ready(or16),
    .result(r16[2]), .neg(ng16[2]), .carry(cy16[2])
  );

  // Reference: plain integer arithmetic on the full operands
  function automatic exp_t model(input int unsigned w, input logic [15:0] ta, input logic [15:0] tb,
                                 input logic [1:0] tm, input int n);
    exp_t        e;
    logic [16:0] s;
    logic [15:0] mask;
    logic        ge;
    mask = 16'((32'd1 << w) - 32'd1);
    ge   = (ta >= tb);
    e.lat = n;
    if (tm == 2'b00) begin
      s       = {1'b0, ta} + {1'b0, tb};
      e.res   = s[15:0] & mask;
      e.carry = s[w];
      e.neg   = 1'b0;
    end else begin
      e.carry = ge;
      e.neg   = !ge;
      case (tm)
        2'b01:   e.res = (ta - tb) & mask;
        2'b10: begin
          e.res = ge ? (ta - tb) : (tb - ta);
          if (!ge) e.lat = 2 * n;
        end
        default: e.res = ge ? (ta - tb) : 16'd0;
      endcase
    end
    return e;
  endfunction

  task automatic run8(input string name, input logic [7:0] ta, input logic [7:0] tb,
                      input logic [1:0] tm, input bit scramble);
    int   k;
    int   lat;
    exp_t e;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL %s_ready: in_ready=%b, expected 1 within 50 cycles", name, in_ready);
      return;
    end
    a = ta; b = tb; mode = tm; in_valid = 1'b1;
    q8.push_back(model(8, 16'(ta), 16'(tb), tm, 2));
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (scramble) begin
      a = ~ta; b = ta ^ 8'h33; mode = ~tm;
    end
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 100);
    e = q8.pop_front();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_valid: out_valid never rose within %0d cycles", name, lat);
      return;
    end
    checks++;
    if (result !== e.res[7:0]) begin
      failures++;
      $display("FAIL %s_result: got %h, expected %h", name, result, e.res[7:0]);
    end
    checks++;
    if (neg !== e.neg || carry !== e.carry) begin
      failures++;
      $display("FAIL %s_flags: got neg=%b carry=%b, expected neg=%b carry=%b", name, neg, carry, e.neg, e.carry);
    end
    checks++;
    if (lat !== e.lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d, expected %0d", name, lat, e.lat);
    end
    if (out_ready) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 8'h00 || neg !== 1'b0 || carry !== 1'b0) begin
      failures++;
      $display("FAIL reset: got in_ready=%b out_valid=%b result=%h neg=%b carry=%b, expected 1 0 00 0 0",
               in_ready, out_valid, result, neg, carry);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_modes();
    run8("absdiff_lt", 8'd3, 8'd10, 2'b10, 1'b0);
    run8("sub_lt", 8'd3, 8'd10, 2'b01, 1'b0);
    run8("satsub_lt", 8'd3, 8'd10, 2'b11, 1'b0);
    run8("add_ovf", 8'd200, 8'd100, 2'b00, 1'b0);
    run8("absdiff_eq", 8'h5A, 8'h5A, 2'b10, 1'b0);
    run8("sub_eq", 8'h5A, 8'h5A, 2'b01, 1'b0);
    run8("absdiff_gt", 8'd200, 8'd55, 2'b10, 1'b0);
    run8("satsub_gt", 8'hF0, 8'h0F, 2'b11, 1'b0);
    run8("sub_scramble", 8'hC3, 8'h7E, 2'b01, 1'b1);
    run8("absdiff_scramble", 8'h11, 8'hEE, 2'b10, 1'b1);
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit   bad;
    int   lat;
    out_ready = 1'b0;
    run8("bp_first", 8'h21, 8'h13, 2'b01, 1'b1);
    e = model(8, 16'h21, 16'h13, 2'b01, 2);
    bad = 1'b0;
    in_valid = 1'b1; a = 8'h40; b = 8'h08; mode = 2'b00;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e.res[7:0] || neg !== e.neg || carry !== e.carry)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL bp_hold: got out_valid=%b in_ready=%b result=%h, expected 1 0 %h", out_valid, in_ready, result, e.res[7:0]);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: got in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    q8.push_back(model(8, 16'h40, 16'h08, 2'b00, 2));
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 100);
    e = q8.pop_front();
    checks++;
    if (out_valid !== 1'b1 || result !== e.res[7:0] || lat !== e.lat) begin
      failures++;
      $display("FAIL bp_next: got valid=%b result=%h lat=%0d, expected 1 %h %0d", out_valid, result, lat, e.res[7:0], e.lat);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit stale;
    in_valid = 1'b1; a = 8'd3; b = 8'd10; mode = 2'b10;
    q8.push_back(model(8, 16'd3, 16'd10, 2'b10, 2));
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 8'h00 || neg !== 1'b0 || carry !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: got out_valid=%b in_ready=%b result=%h neg=%b carry=%b, expected 0 1 00 0 0",
               out_valid, in_ready, result, neg, carry);
    end
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      failures++;
      $display("FAIL reset_stale: got out_valid=%b in_ready=%b after release, expected 0 1", out_valid, in_ready);
    end
    run8("after_reset", 8'd3, 8'd10, 2'b10, 1'b0);
  endtask

  task automatic test_sweep();
    int          nsl[3] = '{16, 4, 1};
    bit          seen[3];
    int          k, lat;
    logic [15:0] ta, tb;
    logic [1:0]  tm;
    exp_t        e;
    for (int i = 0; i < 40; i++) begin
      k = 0;
      while (!(ir16[0] && ir16[1] && ir16[2]) && k < 100) begin
        @(negedge clk);
        k++;
      end
      if (!(ir16[0] && ir16[1] && ir16[2])) begin
        checks++; failures++;
        $display("FAIL sweep_ready: in_ready=%b%b%b, expected 111", ir16[0], ir16[1], ir16[2]);
        return;
      end
      ta = 16'($urandom);
      tb = (i % 8 == 0) ? ta : 16'($urandom);
      tm = 2'($urandom_range(0, 3));
      a16 = ta; b16 = tb; m16 = tm; iv16 = 1'b1;
      for (int j = 0; j < 3; j++) qs[j].push_back(model(16, ta, tb, tm, nsl[j]));
      @(posedge clk);
      #1 iv16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom);
      seen = '{1'b0, 1'b0, 1'b0};
      lat = 0;
      while (!(seen[0] && seen[1] && seen[2]) && lat < 80) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
          if (ov16[j] && !seen[j]) begin
            seen[j] = 1'b1;
            e = qs[j].pop_front();
            checks++;
            if (r16[j] !== e.res || ng16[j] !== e.neg || cy16[j] !== e.carry || lat !== e.lat) begin
              failures++;
              $display("FAIL sweep_chunk%0d: a=%h b=%h mode=%0d got res=%h neg=%b carry=%b lat=%0d, expected res=%h neg=%b carry=%b lat=%0d",
                       16 / nsl[j], ta, tb, tm, r16[j], ng16[j], cy16[j], lat, e.res, e.neg, e.carry, e.lat);
            end
          end
        end
      end
      if (!(seen[0] && seen[1] && seen[2])) begin
        checks++; failures++;
        $display("FAIL sweep_timeout: seen=%b%b%b, expected 111", seen[0], seen[1], seen[2]);
        return;
      end
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
